// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// Latency: n/a (types only).  Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_WORD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_COUNT = 2'd1,
        ERR_UPPER = 2'd2,
        ERR_CSUM  = 2'd3
    } err_code_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_LEN        = 2;
    localparam int WORD_W         = BYTES_PER_WORD * 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/loader_word_asm.sv
// LSB-first byte-to-word assembler; word_done strobes on the last byte of a word.
// Latency: word is combinational with the final byte.  Backpressure: advances only on en.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-9:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            sr  <= '0;
        end else if (clr) begin
            idx <= '0;
            sr  <= '0;
        end else if (en) begin
            idx <= idx + IDX_W'(1);
            sr  <= {byte_in, sr[WORD_W-9:8]};
        end
    end

    // The incoming byte is the top byte, so the full word is visible while it is accepted.
    assign word      = {byte_in, sr};
    assign word_done = en && (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Frame loader: count, LSB-first words and XOR checksum written into instruction memory.
// Latency: imem_we one cycle after each 4th word byte; done/error one cycle after the deciding byte.
// Backpressure: in_ready low in IDLE, WRITE, DONE and ERR; in_valid gaps stall without side effects.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int INST_W = 26,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam int            NW      = HDR_LEN * 8;
    localparam int            CW      = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t            state, state_nxt;
    err_code_t         err_code, code_nxt;
    logic [7:0]        xor_acc, xor_nxt;
    logic [7:0]        cnt_hi, cnt_hi_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [ADDR_W-1:0] widx, widx_nxt;
    logic [ADDR_W-1:0] addr_nxt, wl_nxt;
    logic [INST_W-1:0] data_nxt;
    logic              we_nxt;
    logic [NW-1:0]     n_full;
    logic              xfer;
    logic              asm_en;
    logic              asm_clr;
    logic [WORD_W-1:0] asm_word;
    logic              asm_done;

    assign xfer       = in_valid && in_ready;
    assign asm_en     = xfer && (state == S_WORD);
    assign n_full     = {cnt_hi, in_data};
    assign error_code = err_code;

    loader_word_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .en        (asm_en),
        .byte_in   (in_data),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_comb begin
        state_nxt  = state;
        code_nxt   = err_code;
        xor_nxt    = xor_acc;
        cnt_hi_nxt = cnt_hi;
        count_nxt  = count;
        widx_nxt   = widx;
        addr_nxt   = imem_addr;
        data_nxt   = imem_data;
        wl_nxt     = words_loaded;
        we_nxt     = 1'b0;
        asm_clr    = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_CNT_HI;
                    code_nxt  = ERR_NONE;
                    xor_nxt   = '0;
                    widx_nxt  = '0;
                    addr_nxt  = '0;
                    wl_nxt    = '0;
                    asm_clr   = 1'b1;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    cnt_hi_nxt = in_data;
                    xor_nxt    = xor_acc ^ in_data;
                    state_nxt  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    xor_nxt   = xor_acc ^ in_data;
                    count_nxt = CW'(n_full);
                    if (CW'(n_full) > DEPTH_C) begin
                        state_nxt = S_ERR;
                        code_nxt  = ERR_COUNT;
                    end else if (n_full == '0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_WORD;
                    end
                end
            end
            S_WORD: begin
                if (xfer) begin
                    xor_nxt = xor_acc ^ in_data;
                    if (asm_done) begin
                        if (asm_word[WORD_W-1:INST_W] != '0) begin
                            state_nxt = S_ERR;
                            code_nxt  = ERR_UPPER;
                        end else begin
                            state_nxt = S_WRITE;
                            we_nxt    = 1'b1;
                            data_nxt  = asm_word[INST_W-1:0];
                            addr_nxt  = widx;
                            widx_nxt  = widx + ADDR_W'(1);
                            wl_nxt    = widx + ADDR_W'(1);
                        end
                    end
                end
            end
            S_WRITE: begin
                // widx already points past the word being written this cycle.
                state_nxt = ({1'b0, widx} == count) ? S_CHECK : S_WORD;
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == xor_acc) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                        code_nxt  = ERR_CSUM;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status flags are registered decodes of the next state so they track state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            err_code     <= ERR_NONE;
            xor_acc      <= '0;
            cnt_hi       <= '0;
            count        <= '0;
            widx         <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_data    <= '0;
            words_loaded <= '0;
            in_ready     <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            err_code     <= code_nxt;
            xor_acc      <= xor_nxt;
            cnt_hi       <= cnt_hi_nxt;
            count        <= count_nxt;
            widx         <= widx_nxt;
            imem_we      <= we_nxt;
            imem_addr    <= addr_nxt;
            imem_data    <= data_nxt;
            words_loaded <= wl_nxt;
            in_ready     <= state_nxt inside {S_CNT_HI, S_CNT_LO, S_WORD, S_CHECK};
            cpu_hold     <= (state_nxt != S_DONE);
            done         <= (state_nxt == S_DONE);
            error        <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed frame vectors plus reset-abort and full-depth sequences for imem_loader.
// Latency: checks write timing one cycle after each 4th word byte.  Backpressure: honours in_ready.
module tb_imem_loader;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [25:0] imem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [15:0] words_loaded;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] wr_addr[$];
    logic [25:0] wr_data[$];

    typedef struct {
        int           len;
        logic [127:0] frame;
        logic         exp_done;
        logic [1:0]   exp_code;
        int           exp_wl;
        logic [25:0]  w0;
        logic [25:0]  w1;
        bit           gaps;
    } vec_t;

    vec_t vt[6];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(16), .INST_W(26), .DEPTH(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .error_code   (error_code),
        .words_loaded (words_loaded)
    );

    always @(negedge clk) begin
        if (rst && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_byte: in_ready stuck low, got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, " cpu_hold"},     32'(cpu_hold),     32'd1);
        chk({nm, " in_ready"},     32'(in_ready),     32'd0);
        chk({nm, " imem_we"},      32'(imem_we),      32'd0);
        chk({nm, " done"},         32'(done),         32'd0);
        chk({nm, " error"},        32'(error),        32'd0);
        chk({nm, " imem_addr"},    32'(imem_addr),    32'd0);
        chk({nm, " imem_data"},    32'(imem_data),    32'd0);
        chk({nm, " error_code"},   32'(error_code),   32'd0);
        chk({nm, " words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        chk({nm, " ready_after_start"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < v.len; i++) begin
            send_byte(v.frame[127-8*i -: 8], v.gaps);
            if (i >= 2 && ((i - 2) % 4) == 3 && ((i - 2) / 4) < v.exp_wl)
                chk({nm, " we_after_byte3"}, 32'(imem_we), 32'd1);
        end
        chk({nm, " done"},         32'(done),         32'(v.exp_done));
        chk({nm, " error"},        32'(error),        32'(!v.exp_done));
        chk({nm, " error_code"},   32'(error_code),   32'(v.exp_code));
        chk({nm, " cpu_hold"},     32'(cpu_hold),     32'(!v.exp_done));
        chk({nm, " in_ready"},     32'(in_ready),     32'd0);
        chk({nm, " words_loaded"}, 32'(words_loaded), 32'(v.exp_wl));
        repeat (3) @(negedge clk);
        chk({nm, " done_held"},    32'(done),         32'(v.exp_done));
        chk({nm, " n_writes"},     32'(wr_addr.size()), 32'(v.exp_wl));
        if (wr_addr.size() > 0) begin
            chk({nm, " addr0"}, 32'(wr_addr[0]), 32'd0);
            chk({nm, " data0"}, 32'(wr_data[0]), 32'(v.w0));
        end
        if (wr_addr.size() > 1) begin
            chk({nm, " addr1"}, 32'(wr_addr[1]), 32'd1);
            chk({nm, " data1"}, 32'(wr_data[1]), 32'(v.w1));
        end
    endtask

    initial begin
        vt[0] = '{11, {88'h0002_0100_0000_FFFF_FF03_FF, 40'h0}, 1'b1, 2'd0, 2, 26'h0000001, 26'h3FFFFFF, 1'b0};
        vt[1] = '{3,  {24'h00_0000, 104'h0},                     1'b1, 2'd0, 0, 26'h0,       26'h0,       1'b0};
        vt[2] = '{2,  {16'h0401, 112'h0},                        1'b0, 2'd1, 0, 26'h0,       26'h0,       1'b0};
        vt[3] = '{10, {80'h0002_0100_0000_FFFF_FF04, 48'h0},     1'b0, 2'd2, 1, 26'h0000001, 26'h0,       1'b0};
        vt[4] = '{11, {88'h0002_0100_0000_FFFF_FF03_00, 40'h0},  1'b0, 2'd3, 2, 26'h0000001, 26'h3FFFFFF, 1'b1};
        vt[5] = '{7,  {56'h0001_7856_3402_19, 72'h0},            1'b1, 2'd0, 1, 26'h2345678, 26'h0,       1'b1};

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle ready", 32'(in_ready), 32'd0);

        for (int k = 0; k < 6; k++)
            run_vec(vt[k], $sformatf("vec%0d", k));

        // Abort mid-word, then reload cleanly.
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        vt[0].gaps = 1'b1;
        run_vec(vt[0], "after_reset");

        // Full-depth frame: count == DEPTH is legal, all-zero words, checksum 0x04.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 4096; i++)
            send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        chk("depth done",         32'(done),            32'd1);
        chk("depth words_loaded", 32'(words_loaded),    32'd1024);
        chk("depth n_writes",     32'(wr_addr.size()),  32'd1024);
        if (wr_addr.size() == 1024)
            chk("depth last_addr", 32'(wr_addr[1023]), 32'd1023);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader: the write side of the instruction memory that the pipelined core fetches from. Accepts a byte-stream frame over a valid/ready handshake and assembles 26-bit instruction words. Writes them to instruction memory at consecutive 16-bit addresses starting at 0, holding the core in reset until the image is complete and its checksum verified.

## Interface
- `ADDR_W`, 16: instruction-memory address width; matches the core PC width.
- `INST_W`, 26: instruction width.
- `DEPTH`, 1024: maximum words accepted per frame.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle pulse; begins a frame load.
- `in_valid`  in  1: byte on `in_data` is valid.
- `in_data`  in  8: frame byte.
- `in_ready`  out  1: loader accepts a byte this cycle; transfer when `in_valid && in_ready`.
- `imem_we`  out  1: instruction-memory write enable.
- `imem_addr`  out  ADDR_W: write address.
- `imem_data`  out  INST_W: write data.
- `cpu_hold`  out  1: holds the core in reset while high.
- `done`  out  1: frame loaded and verified (level).
- `error`  out  1: frame rejected (level).
- `error_code`  out  2: 0 none, 1 count > DEPTH, 2 upper instruction bits nonzero, 3 checksum mismatch.
- `words_loaded`  out  ADDR_W: words written in the current/last frame.

## Operation
- Frame layout:
  - count N: 2 bytes, MSB first.
  - N words, 4 bytes each, LSB first.
  - checksum: 1 byte, XOR of every preceding frame byte, count bytes included.
- States:
  - IDLE: `start` → CNT_HI.
  - CNT_HI: byte accepted → CNT_LO.
  - CNT_LO: byte accepted; N > DEPTH → ERR (code 1); N = 0 → CHECK; else → WORD.
  - WORD: accepts 4 bytes (idx 0..3). On byte 3: bits [31:26] nonzero → ERR (code 2); else → WRITE.
  - WRITE: one cycle; `imem_we`=1, `imem_data`=assembled[25:0], `imem_addr`=word index; `words_loaded` += 1. Last word → CHECK, else → WORD.
  - CHECK: byte accepted; equal to running XOR → DONE, else → ERR (code 3).
  - DONE, ERR: `start` → CNT_HI (clears `done`, `error`, `error_code`, `words_loaded`, XOR, address; sets `cpu_hold`).
- `start` is ignored in every other state.
- `in_ready` = 1 only in CNT_HI, CNT_LO, WORD and CHECK; 0 in IDLE, WRITE, DONE and ERR.
- `cpu_hold` = 1 in every state except DONE. It stays 1 after an error.
- Words written before an error remain in memory; `words_loaded` reports how many.
- Address arithmetic: word index counts 0..N-1 in ADDR_W bits. No wrap is possible because N ≤ DEPTH ≤ 2^ADDR_W.

## Timing
- Reset values (async, rst=0): state IDLE.
  - `cpu_hold`=1.
  - `in_ready`, `imem_we`, `done`, `error` = 0.
  - `imem_addr`, `imem_data`, `error_code`, `words_loaded`, XOR, byte index = 0.
- Reset mid-frame aborts immediately and returns to reset values. Memory contents are not restored.
- All outputs are registered. `imem_we` is high for exactly one cycle per word: the cycle after the word's 4th byte is accepted.
- Minimum throughput: 5 cycles per word (4 transfers + WRITE). Gaps in `in_valid` stall the state without side effects.
- `done`/`error` assert the cycle after the checksum byte (or the offending byte) is accepted, and hold until `start` or reset.
- `cpu_hold` falls in the same cycle `done` rises.

## Structure
- Package `imem_loader_pkg`:
  - state enum;
  - error-code enum;
  - `BYTES_PER_WORD`=4;
  - frame header length 2.
- Sub-module `loader_word_asm`: 4-byte LSB-first shift assembler with byte index, clear and word-complete strobe. Used by WORD state.
- Checksum XOR and counters live in the top FSM.

## Test plan
- Frame 00 02 | 01 00 00 00 | FF FF FF 03 | FF → two writes: (addr 0, 0x0000001), (addr 1, 0x3FFFFFF); then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Frame 00 00 | 00 → no `imem_we`; `done`=1; `cpu_hold`=0.
- Count 0x0401 with DEPTH=1024 → `error`=1, code 1, after 2nd byte; no writes; `cpu_hold`=1; `in_ready`=0.
- N=2, second word byte 3 = 0x04 → word 0 written at addr 0; `error`, code 2; `words_loaded`=1; no second write.
- First frame with checksum 0x00 instead of 0xFF → both words written, then code 3, `cpu_hold`=1. New `start` plus correct frame → `done`.
- Random `in_valid` gaps, with `rst` low mid-WORD for 1 cycle → all outputs at reset values. A subsequent `start` plus valid frame loads correctly, with writes one cycle after each 4th byte.
